// File: rtl/capture_sequencer_pkg.sv
// Shared constants for the logic-analyzer capture sequencer: default sizes and
// the acquisition state encoding used by the sequencer and status readout.
package capture_sequencer_pkg;

  localparam int unsigned WIDTH_DEF  = 8;
  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DIV_W_DEF  = 16;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_FILL = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_POST = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_FILL = ST_FILL,
    S_WAIT = ST_WAIT,
    S_POST = ST_POST,
    S_DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/capture_sequencer_sample_divider.sv
// Sample-rate divider: counts 0..period and flags a tick on the terminal count.
// load latches a new period and restarts; clear restarts without touching it.
module sample_divider
  import capture_sequencer_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             load,
  input  logic             clear,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick_c
);

  logic [DIV_W-1:0] period;
  logic [DIV_W-1:0] cnt;

  assign tick_c = en && (cnt == period);

  // period shadow and free-running count, restarted on load/clear
  always_ff @(posedge clk) begin
    if (!nreset) begin
      period <= '0;
      cnt    <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      period <= div;
      cnt    <= '0;
    end else if (en) begin
      cnt <= tick_c ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/capture_sequencer.sv
// Acquisition controller: strobes the capture register, writes samples into a
// ring buffer, evaluates a mask/value trigger and reports the window addresses.
module capture_sequencer
  import capture_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DIV_W  = DIV_W_DEF
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              arm,
  input  logic              abort,
  input  logic [DIV_W-1:0]  div,
  input  logic [ADDR_W-1:0] pre_count,
  input  logic [ADDR_W-1:0] post_count,
  input  logic [WIDTH-1:0]  trig_mask,
  input  logic [WIDTH-1:0]  trig_value,
  input  logic              trig_edge,
  input  logic [WIDTH-1:0]  probe_in,
  output logic              smp_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] start_addr,
  output logic              busy,
  output logic              done
);

  state_e            state;

  // configuration shadowed at arm so host writes mid-run have no effect
  logic [ADDR_W-1:0] pre_s;
  logic [ADDR_W-1:0] post_s;
  logic [WIDTH-1:0]  mask_s;
  logic [WIDTH-1:0]  value_s;
  logic              edge_s;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] fill_cnt;
  logic [ADDR_W-1:0] post_cnt;
  logic              prev_match;

  logic              arm_ok_c;
  logic              running_c;
  logic              post_last_c;
  logic              div_en_c;
  logic              tick_c;
  logic              match_c;
  logic              hit_c;

  // arm only from IDLE/DONE, and abort beats a simultaneous arm
  assign arm_ok_c    = arm && !abort && (state == S_IDLE || state == S_DONE);
  assign running_c   = (state == S_FILL) || (state == S_WAIT) || (state == S_POST);
  // the cycle after the final post write: no further tick, leave for DONE
  assign post_last_c = (state == S_POST) && (post_cnt == post_s);
  assign div_en_c    = running_c && !post_last_c;

  assign match_c = ((probe_in ^ value_s) & mask_s) == '0;
  assign hit_c   = edge_s ? (match_c && !prev_match) : match_c;

  assign smp_en = tick_c;

  sample_divider #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk    (clk),
    .nreset (nreset),
    .load   (arm_ok_c),
    .clear  (abort),
    .en     (div_en_c),
    .div    (div),
    .tick_c (tick_c)
  );

  // acquisition state machine, sample writes and trigger bookkeeping
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state      <= S_IDLE;
      pre_s      <= '0;
      post_s     <= '0;
      mask_s     <= '0;
      value_s    <= '0;
      edge_s     <= 1'b0;
      wr_ptr     <= '0;
      fill_cnt   <= '0;
      post_cnt   <= '0;
      prev_match <= 1'b0;
      mem_we     <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      trig_addr  <= '0;
      start_addr <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else if (arm_ok_c) begin
        pre_s      <= pre_count;
        post_s     <= post_count;
        mask_s     <= trig_mask;
        value_s    <= trig_value;
        edge_s     <= trig_edge;
        wr_ptr     <= '0;
        fill_cnt   <= '0;
        post_cnt   <= '0;
        prev_match <= 1'b1;
        busy       <= 1'b1;
        done       <= 1'b0;
        state      <= (pre_count == '0) ? S_WAIT : S_FILL;
      end else begin
        // every tick stores the tick-cycle probe word one cycle later
        if (tick_c) begin
          mem_we    <= 1'b1;
          mem_waddr <= wr_ptr;
          mem_wdata <= probe_in;
          wr_ptr    <= wr_ptr + ADDR_W'(1);
        end
        case (state)
          S_FILL: begin
            if (tick_c) begin
              prev_match <= match_c;
              fill_cnt   <= fill_cnt + ADDR_W'(1);
              if (fill_cnt + ADDR_W'(1) == pre_s) begin
                state <= S_WAIT;
              end
            end
          end
          S_WAIT: begin
            if (tick_c) begin
              prev_match <= match_c;
              if (hit_c) begin
                trig_addr  <= wr_ptr;
                start_addr <= wr_ptr - pre_s;
                if (post_s == '0) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end else begin
                  state <= S_POST;
                end
              end
            end
          end
          S_POST: begin
            if (post_last_c) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (tick_c) begin
              post_cnt <= post_cnt + ADDR_W'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
Acquisition controller for the logic-analyzer sample path. It generates the sample-enable strobe that clocks probe data into the capture register, and it writes the samples into a ring-buffer sample memory. It evaluates a mask/value trigger and counts pre-trigger and post-trigger samples. It reports the trigger and window-start addresses to the readout logic. It sits between the host-configured control registers and the sample memory.

Parameters:
WIDTH, 8, number of probe channels (sample word width)
ADDR_W, 10, sample memory address width; depth = 2^ADDR_W
DIV_W, 16, width of sample-rate divider

Ports:
clk  in  1  system clock
nreset  in  1  reset
arm  in  1  one-cycle pulse: latch config, start acquisition
abort  in  1  one-cycle pulse: stop acquisition, return to IDLE
div  in  DIV_W  sample period minus one, in clk cycles
pre_count  in  ADDR_W  pre-trigger samples required before trigger is accepted
post_count  in  ADDR_W  samples stored after the trigger sample
trig_mask  in  WIDTH  channels that take part in the trigger
trig_value  in  WIDTH  required level per masked channel
trig_edge  in  1  0 = level match, 1 = match onset only
probe_in  in  WIDTH  probe data, already synchronised to clk
smp_en  out  1  sample strobe (capture register enable)
mem_we  out  1  sample memory write enable
mem_waddr  out  ADDR_W  write address
mem_wdata  out  WIDTH  write data
trig_addr  out  ADDR_W  address of the trigger sample
start_addr  out  ADDR_W  oldest sample of the window = trig_addr - pre_count (mod 2^ADDR_W)
busy  out  1  high in FILL/WAIT/POST
done  out  1  high in DONE

Behaviour:
- Reset: nreset is synchronous and active-low; clock is clk. On reset, state = IDLE and every output = 0. Divider, pointers, counters and shadow config all = 0. Reset has priority over all inputs in any state, mid-acquisition included.
- States: IDLE, FILL, WAIT, POST, DONE. A 3-bit encoding is sufficient.
- arm is accepted in IDLE or DONE only and ignored otherwise. On acceptance:
  - div, pre_count, post_count, trig_mask, trig_value and trig_edge are latched into shadow registers.
  - The divider counter and wr_ptr are set to 0, fill_cnt and post_cnt to 0, and prev_match to 1.
  - done is cleared.
  - Next state is FILL, or WAIT if pre_count == 0.
- abort in any non-IDLE state goes to IDLE next cycle. No further mem_we occurs and done = 0. If arm and abort arrive together, abort wins.
- Divider:
  - Runs only in FILL/WAIT/POST. The counter counts 0..div_s, and a tick occurs in the cycle the counter equals div_s; the counter then returns to 0.
  - div = 0 gives a tick every cycle.
  - The first tick comes div_s+1 cycles after the arm cycle.
- smp_en equals the tick (combinational from the state and counter registers).
- Sample write on each tick:
  - In the next cycle, mem_we = 1, mem_wdata = probe_in as it was in the tick cycle, and mem_waddr = wr_ptr.
  - wr_ptr then increments modulo 2^ADDR_W; wrap 2^ADDR_W-1 -> 0 is silent.
  - Write latency is 1 cycle. mem_we is never high for two consecutive cycles unless div = 0.
- Trigger evaluation uses the tick-cycle probe_in.
  - match = ((probe_in ^ trig_value_s) & trig_mask_s) == 0, so mask = 0 always matches.
  - With edge = 0, hit = match. With edge = 1, hit = match & ~prev_match.
  - prev_match is updated on every tick in FILL and WAIT. Because it is initialised to 1, a condition already true at arm does not fire in edge mode.
- FILL: each tick increments fill_cnt. When the count of written samples reaches pre_count_s, go to WAIT. Hits are ignored in FILL.
- WAIT: on a tick with hit, the sample is written and trig_addr = its address. If post_count_s == 0 go to DONE, otherwise go to POST.
- POST: each tick writes a sample and increments post_cnt. When post_cnt reaches post_count_s, go to DONE in the cycle after the last mem_we.
- Total samples per run = pre_count + (WAIT samples) + 1 + post_count.
- If pre_count + post_count >= 2^ADDR_W, the oldest samples are overwritten; no error is flagged.
- DONE: busy = 0, done = 1, no writes. trig_addr and start_addr hold until the next arm or reset.
- start_addr is registered and updated together with trig_addr.
- probe_in changing between ticks has no effect.

Decomposition:
- Shared package holds:
  - the state encoding localparams (ST_IDLE … ST_DONE), used by the status readout logic;
  - the default WIDTH/ADDR_W/DIV_W constants.
- One natural sub-module is sample_divider: a DIV_W counter with load/clear and a tick output. The trigger compare stays inline.

Test Plan:
1. div=0, pre=2, post=3, edge=0, mask=FF, value=A5; probe per cycle 00,11,22,A5,33,44,55 from the first tick -> 7 writes, addr 0..6, data as given. trig_addr=3, start_addr=1, done rises the cycle after the addr-6 write, busy falls with it.
2. div=3, pre=0, mask=00 -> trigger on the first tick (4th cycle after arm), mem_we exactly 1 cycle in 4, then done after post_count writes.
3. edge=1, mask=01, value=01, probe bit0 held 1 from arm, dropped for 2 ticks, then raised -> no trigger while held; trig_addr = address of the first tick with bit0 back at 1.
4. ADDR_W=4 build, pre=0, post=2, trigger on the 20th sample -> waddr wraps 15->0, trig_addr=3 (19 mod 16), last write addr 5.
5. abort during POST after 1 of 3 post samples -> IDLE next cycle, no further mem_we, done=0. A re-arm restarts at addr 0 and completes normally.
6. nreset low for 1 cycle during WAIT -> all outputs 0 next cycle, state IDLE; arm and abort are ignored while nreset is low.
